// File: rtl/serial_add_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_add_pkg : shared state encoding and slice width           |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 2;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_add2_slice.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | add2_slice : combinational 2-bit full adder                      |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
module add2_slice
    import serial_add_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, ci};

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_add_ctrl : WIDTH-bit add using one 2-bit slice, LSB first |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = $clog2(N) + 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] x_sel;
    logic [SLICE_W-1:0] y_sel;
    logic [SLICE_W-1:0] s_slice;
    logic               co_slice;
    logic               last;

    assign last = (idx == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand slice mux; the captured operands stay in place.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                x_sel = a_r[k*SLICE_W +: SLICE_W];
                y_sel = b_r[k*SLICE_W +: SLICE_W];
            end
        end
    end

    add2_slice u_slice (
        .x  (x_sel),
        .y  (y_sel),
        .ci (carry),
        .s  (s_slice),
        .co (co_slice)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next != IDLE);
            done_r <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        carry  <= cin;
                        idx    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx == IDX_W'(k)) begin
                            sum_r[k*SLICE_W +: SLICE_W] <= s_slice;
                        end
                    end
                    carry <= co_slice;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout_r <= co_slice;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_serial_add_ctrl : directed checks on WIDTH=8 and WIDTH=2 DUTs |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    // Drives one start pulse; returns just after the accepting edge (cycle 1).
    task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", busy, done, sum, cout);
        end
        n_checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || sum2 !== 2'd0 || cout2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset2: busy=%b done=%b sum=%h cout=%b, required 0 0 0 0", busy2, done2, sum2, cout2);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        issue(8'h5A, 8'h3C, 1'b0);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== (cyc <= 5) || done !== (cyc == 5)) begin
                n_fail++;
                $display("FAIL basic_timing cyc%0d: busy=%b done=%b, required busy=%b done=%b",
                         cyc, busy, done, cyc <= 5, cyc == 5);
            end
            if (cyc >= 5) begin
                n_checks++;
                if (sum !== 8'h96 || cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_result cyc%0d: sum=%h cout=%b, required 96 0", cyc, sum, cout);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_carry();
        logic [7:0] va [2] = '{8'hFF, 8'hFF};
        logic [7:0] vb [2] = '{8'h01, 8'hFF};
        logic       vc [2] = '{1'b0, 1'b1};
        logic [7:0] es [2] = '{8'h00, 8'hFF};
        logic       ec [2] = '{1'b1, 1'b1};
        for (int t = 0; t < 2; t++) begin
            int lat;
            lat = 0;
            issue(va[t], vb[t], vc[t]);
            for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
                @(negedge clk);
                if (done === 1'b1) lat = cyc;
                @(posedge clk); #1;
            end
            n_checks++;
            if (lat != 5) begin
                n_fail++;
                $display("FAIL carry%0d_latency: done at cycle %0d, required 5", t, lat);
            end
            n_checks++;
            if (sum !== es[t] || cout !== ec[t]) begin
                n_fail++;
                $display("FAIL carry%0d_result: sum=%h cout=%b, required %h %b", t, sum, cout, es[t], ec[t]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        n_done = 0;
        issue(8'h12, 8'h34, 1'b0);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
            if (cyc == 4) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                n_checks++;
                if (sum !== 8'h46 || cout !== 1'b0 || cyc != 5) begin
                    n_fail++;
                    $display("FAIL ignore_result: cyc=%0d sum=%h cout=%b, required cyc 5 sum 46 cout 0", cyc, sum, cout);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: %0d done pulses, required 1", n_done);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        issue(8'hAA, 8'h55, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", busy, done, sum, cout);
        end
        @(posedge clk); #1;
        lat = 0;
        issue(8'h01, 8'h02, 1'b0);
        for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) lat = cyc;
            @(posedge clk); #1;
        end
        n_checks++;
        if (lat != 5 || sum !== 8'h03 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_after: lat=%0d sum=%h cout=%b, required 5 03 0", lat, sum, cout);
        end
    endtask

    task automatic test_width2();
        @(negedge clk);
        start2 = 1'b1; a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (done2 !== (cyc == 2) || busy2 !== (cyc <= 2)) begin
                n_fail++;
                $display("FAIL w2_timing cyc%0d: busy=%b done=%b, required %b %b", cyc, busy2, done2, cyc <= 2, cyc == 2);
            end
            if (cyc == 2) begin
                n_checks++;
                if (sum2 !== 2'd3 || cout2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL w2_result: sum=%0d cout=%b, required 3 1", sum2, cout2);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== ((cyc % 6) != 0) || done !== ((cyc % 6) == 5)) begin
                n_fail++;
                $display("FAIL b2b_timing cyc%0d: busy=%b done=%b, required %b %b",
                         cyc, busy, done, (cyc % 6) != 0, (cyc % 6) == 5);
            end
            if ((cyc % 6) == 5) begin
                n_checks++;
                if (sum !== 8'h30 || cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result cyc%0d: sum=%h cout=%b, required 30 0", cyc, sum, cout);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_mid_reset();
        test_width2();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle sequencer that adds two WIDTH-bit operands by driving one 2-bit full-adder slice over WIDTH/2 clock cycles, least-significant pair first. The block latches operands on a start pulse, steps a slice index, and propagates carry between steps through a register. It reports completion with a one-cycle done pulse. It sits between a simple start/done requester (switch/button logic, a test FSM) and the 2-bit adder datapath, trading latency for a single small adder.

## Interface
- WIDTH, 8, operand/sum width; even, >= 2
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- cin  in  1  carry-in; captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; sum/cout valid
- sum  out  WIDTH  result register
- cout  out  1  final carry-out register

## Operation
- One clock, clk. Reset is synchronous and active-high on rst.
- States: IDLE, RUN, DONE. N = WIDTH/2 slices, index idx is ceil(log2(N))+1 bits wide.
- On the edge where rst=1, from any state including mid-RUN:
  - state goes to IDLE.
  - busy, done, sum, cout, carry and idx all go to 0.
  - The captured operands are cleared.
- IDLE:
  - start=1 loads a, b and cin into internal registers.
  - The same edge sets carry=cin, idx=0, sum=0 and cout=0, and moves to RUN.
  - start=0 holds all state.
  - sum and cout keep the previous result.
- RUN, on each edge:
  - s = a_r[2i+1:2i] + b_r[2i+1:2i] + carry, where i=idx; the result is 3 bits.
  - sum[2i+1:2i] <= s[1:0]; carry <= s[2]; idx <= idx+1.
  - At idx = N-1: cout <= s[2] and the state moves to DONE.
- DONE: done=1 for exactly this cycle; the next edge returns to IDLE unconditionally.
- start in RUN or DONE is ignored and is not queued.
- Changes on a, b or cin after acceptance do not affect the result.
- sum and cout hold their value in IDLE until the next accepted start.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). There is no overflow flag; unsigned semantics.

## Timing
- Cycle 0: start high, IDLE; accepted at the end of cycle 0.
- Cycles 1..N: RUN, busy=1, one slice per cycle.
- Cycle N+1: DONE, done=1, busy=1, and the final sum/cout are visible.
- Cycle N+2: IDLE, busy=0; the earliest cycle a new start is accepted.
- Latency from start to done is N+1 cycles. Minimum issue interval is N+2 cycles.
- Outputs are registered only; there is no combinational path from any input to any output.
- Reset in any cycle takes effect at that edge: busy and done are 0 in the following cycle.
- start together with rst: rst wins and start is dropped.

## Structure
- Shared package serial_add_pkg:
  - state enum IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - localparam SLICE_W=2.
- Sub-module add2_slice is purely combinational:
  - inputs: x[1:0], y[1:0], ci.
  - outputs: s[1:0], co.
- serial_add_ctrl instantiates add2_slice once. It contains:
  - the FSM;
  - the idx counter;
  - the carry register;
  - the operand registers;
  - the sum register.
- Slice selection is a mux on idx; the operands are not shifted.

## Test plan
- WIDTH=8: start with a=8'h5A, b=8'h3C, cin=0 -> done in cycle 5 only, sum=8'h96, cout=0, busy high in cycles 1-5.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1 (carry ripples through every slice).
- Mid-operation changes: during RUN, pulse start and change a/b/cin -> the result equals the originally captured operands, and done pulses exactly once.
- Reset mid-operation: assert rst in cycle 2 of RUN -> next cycle busy=0, done=0, sum=0, cout=0. A following start with a=8'h01, b=8'h02 gives sum=8'h03.
- WIDTH=2 edge case: a=2'd3, b=2'd3, cin=1 -> done in cycle 2, sum=2'd3, cout=1.
- Back-to-back: start held high continuously with WIDTH=8 -> starts accepted every 6 cycles, each done followed by busy=0 for exactly one cycle.
